// File: rtl/phys_reg_map_table_if.sv
`default_nettype none
// ============================================================================
//  Module      : phys_reg_map_table_if
//  Description : Bundle of lookup, rename, writeback and checkpoint signals
//                between the rename stage (master) and the register map
//                table (slave).
//                  lookup     : rs/rt arch reg in, phys tag + ready out
//                  rename     : dest arch reg + new tag in, old tag out
//                  complete   : CDB writeback tag in
//                  checkpoint : save / restore / clear requests in,
//                               allocated column and success flags out
//  Revision    : 1.0  initial release
// ============================================================================
interface phys_reg_map_table_if #(
    parameter int NUM_ARCH_REGS      = 32,
    parameter int NUM_PHYS_REGS      = 64,
    parameter int CHECKPOINT_COLUMNS = 4,
    parameter int ROB_DEPTH          = 16
);
    localparam int c_arch_w = $clog2(NUM_ARCH_REGS);
    localparam int c_tag_w  = $clog2(NUM_PHYS_REGS);
    localparam int c_col_w  = $clog2(CHECKPOINT_COLUMNS);
    localparam int c_rob_w  = $clog2(ROB_DEPTH);

    logic [c_arch_w-1:0] rs_arch_reg;
    logic [c_arch_w-1:0] rt_arch_reg;
    logic [c_tag_w-1:0]  rs_phys_reg_tag;
    logic                rs_ready;
    logic [c_tag_w-1:0]  rt_phys_reg_tag;
    logic                rt_ready;

    logic                rename_valid;
    logic [c_arch_w-1:0] rename_arch_reg;
    logic [c_tag_w-1:0]  rename_phys_reg_tag;
    logic [c_tag_w-1:0]  rename_old_phys_reg_tag;

    logic                complete_valid;
    logic [c_tag_w-1:0]  complete_phys_reg_tag;

    logic                save_checkpoint_valid;
    logic [c_rob_w-1:0]  save_checkpoint_ROB_index;
    logic [c_col_w-1:0]  save_checkpoint_column;
    logic                save_checkpoint_success;

    logic                restore_checkpoint_valid;
    logic [c_rob_w-1:0]  restore_checkpoint_ROB_index;
    logic [c_col_w-1:0]  restore_checkpoint_column;
    logic                restore_checkpoint_success;

    logic                clear_checkpoint_valid;
    logic [c_col_w-1:0]  clear_checkpoint_column;

    modport master (
        output rs_arch_reg, rt_arch_reg,
        input  rs_phys_reg_tag, rs_ready, rt_phys_reg_tag, rt_ready,
        output rename_valid, rename_arch_reg, rename_phys_reg_tag,
        input  rename_old_phys_reg_tag,
        output complete_valid, complete_phys_reg_tag,
        output save_checkpoint_valid, save_checkpoint_ROB_index,
        input  save_checkpoint_column, save_checkpoint_success,
        output restore_checkpoint_valid, restore_checkpoint_ROB_index,
        output restore_checkpoint_column,
        input  restore_checkpoint_success,
        output clear_checkpoint_valid, clear_checkpoint_column
    );

    modport slave (
        input  rs_arch_reg, rt_arch_reg,
        output rs_phys_reg_tag, rs_ready, rt_phys_reg_tag, rt_ready,
        input  rename_valid, rename_arch_reg, rename_phys_reg_tag,
        output rename_old_phys_reg_tag,
        input  complete_valid, complete_phys_reg_tag,
        input  save_checkpoint_valid, save_checkpoint_ROB_index,
        output save_checkpoint_column, save_checkpoint_success,
        input  restore_checkpoint_valid, restore_checkpoint_ROB_index,
        input  restore_checkpoint_column,
        output restore_checkpoint_success,
        input  clear_checkpoint_valid, clear_checkpoint_column
    );
endinterface
`default_nettype wire

// File: rtl/phys_reg_map_table.sv
`default_nettype none
// ============================================================================
//  Module      : phys_reg_map_table
//  Description : Rename-stage architectural-to-physical register map with a
//                ready bit per mapping and circular per-branch checkpoint
//                columns kept in lockstep with the free list.
//  Ports       : CLK   - clock
//                nRST  - synchronous active-low reset
//                bus   - phys_reg_map_table_if.slave (lookup, rename,
//                        complete, save/restore/clear checkpoint)
//  Revision    : 1.0  initial release
// ============================================================================
module phys_reg_map_table #(
    parameter int NUM_ARCH_REGS      = 32,
    parameter int NUM_PHYS_REGS      = 64,
    parameter int CHECKPOINT_COLUMNS = 4,   // must be a power of two
    parameter int ROB_DEPTH          = 16
) (
    input  wire                  CLK,
    input  wire                  nRST,
    phys_reg_map_table_if.slave  bus
);
    localparam int c_arch_w = $clog2(NUM_ARCH_REGS);
    localparam int c_tag_w  = $clog2(NUM_PHYS_REGS);
    localparam int c_col_w  = $clog2(CHECKPOINT_COLUMNS);
    localparam int c_rob_w  = $clog2(ROB_DEPTH);

    // ---------------------------------------------------------------- state
    logic [c_tag_w-1:0]       r_map      [NUM_ARCH_REGS];
    logic [NUM_ARCH_REGS-1:0] r_ready;
    logic [c_tag_w-1:0]       r_cp_map   [CHECKPOINT_COLUMNS][NUM_ARCH_REGS];
    logic [NUM_ARCH_REGS-1:0] r_cp_ready [CHECKPOINT_COLUMNS];
    logic [c_rob_w-1:0]       r_cp_rob   [CHECKPOINT_COLUMNS];
    logic [CHECKPOINT_COLUMNS-1:0] r_cp_valid;
    logic [c_col_w-1:0]       r_tail;

    // ------------------------------------------------------------ functions
    function automatic logic f_cdb_hit(
        input logic [c_tag_w-1:0] tag,
        input logic               cv,
        input logic [c_tag_w-1:0] ctag
    );
        return cv && (tag == ctag);
    endfunction

    // --------------------------------------------------------- combinational
    logic                          w_restore_ok;
    logic                          w_save_ok;
    logic                          w_rename_we;
    logic [NUM_ARCH_REGS-1:0]      w_ready_cmp;   // live ready incl. CDB
    logic [CHECKPOINT_COLUMNS-1:0] w_kill;        // columns dropped by restore
    logic [c_col_w-1:0]            w_span;

    assign w_restore_ok = bus.restore_checkpoint_valid
                       && r_cp_valid[bus.restore_checkpoint_column]
                       && (r_cp_rob[bus.restore_checkpoint_column]
                           == bus.restore_checkpoint_ROB_index);

    // A successful restore squashes everything younger, so the same-cycle
    // rename and save belong to the wrong path and are dropped.
    assign w_save_ok   = bus.save_checkpoint_valid && !r_cp_valid[r_tail]
                      && !w_restore_ok;
    assign w_rename_we = bus.rename_valid && (bus.rename_arch_reg != '0)
                      && !w_restore_ok;

    // Number of columns from the restored one up to the old tail. A span of
    // zero with a valid restore column means the ring is full: kill all.
    assign w_span = r_tail - bus.restore_checkpoint_column;

    always_comb begin
        w_ready_cmp = '0;
        w_kill      = '0;
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            w_ready_cmp[i] = r_ready[i]
                           | f_cdb_hit(r_map[i], bus.complete_valid,
                                       bus.complete_phys_reg_tag);
        end
        for (int k = 0; k < CHECKPOINT_COLUMNS; k++) begin
            logic [c_col_w-1:0] v_off;
            v_off     = c_col_w'(k) - bus.restore_checkpoint_column;
            w_kill[k] = w_restore_ok && ((w_span == '0) || (v_off < w_span));
        end
    end

    // --------------------------------------------------------------- outputs
    assign bus.rs_phys_reg_tag = r_map[bus.rs_arch_reg];
    assign bus.rs_ready        = r_ready[bus.rs_arch_reg]
                               | f_cdb_hit(r_map[bus.rs_arch_reg],
                                           bus.complete_valid,
                                           bus.complete_phys_reg_tag);
    assign bus.rt_phys_reg_tag = r_map[bus.rt_arch_reg];
    assign bus.rt_ready        = r_ready[bus.rt_arch_reg]
                               | f_cdb_hit(r_map[bus.rt_arch_reg],
                                           bus.complete_valid,
                                           bus.complete_phys_reg_tag);

    assign bus.rename_old_phys_reg_tag = (bus.rename_arch_reg == '0)
                                       ? '0 : r_map[bus.rename_arch_reg];

    assign bus.save_checkpoint_column     = r_tail;
    assign bus.save_checkpoint_success    = w_save_ok;
    assign bus.restore_checkpoint_success = w_restore_ok;

    // ------------------------------------------------------------ sequential
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                r_map[i] <= c_tag_w'(i);
            end
            r_ready <= '1;
            for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
                for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                    r_cp_map[c][i] <= '0;
                end
                r_cp_ready[c] <= '0;
                r_cp_rob[c]   <= '0;
            end
            r_cp_valid <= '0;
            r_tail     <= '0;
        end else begin
            // Live map
            if (w_restore_ok) begin
                for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                    r_map[i]   <= r_cp_map[bus.restore_checkpoint_column][i];
                    r_ready[i] <= r_cp_ready[bus.restore_checkpoint_column][i]
                                | f_cdb_hit(
                                      r_cp_map[bus.restore_checkpoint_column][i],
                                      bus.complete_valid,
                                      bus.complete_phys_reg_tag);
                end
            end else begin
                r_ready <= w_ready_cmp;
                // Written after the CDB update so a rename of the same tag wins
                if (w_rename_we) begin
                    r_map[bus.rename_arch_reg]   <= bus.rename_phys_reg_tag;
                    r_ready[bus.rename_arch_reg] <= 1'b0;
                end
            end

            // Writebacks keep snapshots current so a restore sees them
            for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
                for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                    r_cp_ready[c][i] <= r_cp_ready[c][i]
                                      | f_cdb_hit(r_cp_map[c][i],
                                                  bus.complete_valid,
                                                  bus.complete_phys_reg_tag);
                end
                if (w_kill[c] || (bus.clear_checkpoint_valid
                                  && (bus.clear_checkpoint_column
                                      == c_col_w'(c)))) begin
                    r_cp_valid[c] <= 1'b0;
                end
            end

            // Save comes after clear so a save to the cleared column wins;
            // snapshot is the pre-rename map with the same-cycle writeback.
            if (w_save_ok) begin
                r_cp_map[r_tail]   <= r_map;
                r_cp_ready[r_tail] <= w_ready_cmp;
                r_cp_rob[r_tail]   <= bus.save_checkpoint_ROB_index;
                r_cp_valid[r_tail] <= 1'b1;
                r_tail             <= r_tail + c_col_w'(1);
            end

            if (w_restore_ok) begin
                r_tail <= bus.restore_checkpoint_column + c_col_w'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_phys_reg_map_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phys_reg_map_table
//  Description : Directed vector bench for phys_reg_map_table. Each step
//                drives one cycle of inputs on the falling edge and checks
//                the combinational outputs before the next rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_phys_reg_map_table;
    logic CLK;
    logic nRST;

    phys_reg_map_table_if bus ();

    phys_reg_map_table dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] rs, rt;
        logic       ren;
        logic [4:0] ra;
        logic [5:0] rtag;
        logic       cv;
        logic [5:0] ctag;
        logic       sv;
        logic [3:0] srob;
        logic       rv;
        logic [3:0] rrob;
        logic [1:0] rcol;
        logic       clv;
        logic [1:0] clcol;
    } in_t;

    typedef struct {
        logic [5:0] rs_tag;
        logic       rs_rdy;
        logic [5:0] rt_tag;
        logic       rt_rdy;
        logic [5:0] old_tag;
        logic [1:0] scol;
        logic       sok;
        logic       rok;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    function automatic in_t mk_in(int rs, int rt, int ren, int ra, int rtag,
                                  int cv, int ctag, int sv, int srob,
                                  int rv, int rrob, int rcol, int clv,
                                  int clcol);
        in_t r;
        r.rs = 5'(rs);     r.rt = 5'(rt);
        r.ren = 1'(ren);   r.ra = 5'(ra);     r.rtag = 6'(rtag);
        r.cv = 1'(cv);     r.ctag = 6'(ctag);
        r.sv = 1'(sv);     r.srob = 4'(srob);
        r.rv = 1'(rv);     r.rrob = 4'(rrob); r.rcol = 2'(rcol);
        r.clv = 1'(clv);   r.clcol = 2'(clcol);
        return r;
    endfunction

    function automatic exp_t mk_exp(int rs_tag, int rs_rdy, int rt_tag,
                                    int rt_rdy, int old_tag, int scol,
                                    int sok, int rok);
        exp_t r;
        r.rs_tag = 6'(rs_tag);  r.rs_rdy = 1'(rs_rdy);
        r.rt_tag = 6'(rt_tag);  r.rt_rdy = 1'(rt_rdy);
        r.old_tag = 6'(old_tag);
        r.scol = 2'(scol);      r.sok = 1'(sok);  r.rok = 1'(rok);
        return r;
    endfunction

    task automatic drive(input in_t i);
        bus.rs_arch_reg                  = i.rs;
        bus.rt_arch_reg                  = i.rt;
        bus.rename_valid                 = i.ren;
        bus.rename_arch_reg              = i.ra;
        bus.rename_phys_reg_tag          = i.rtag;
        bus.complete_valid               = i.cv;
        bus.complete_phys_reg_tag        = i.ctag;
        bus.save_checkpoint_valid        = i.sv;
        bus.save_checkpoint_ROB_index    = i.srob;
        bus.restore_checkpoint_valid     = i.rv;
        bus.restore_checkpoint_ROB_index = i.rrob;
        bus.restore_checkpoint_column    = i.rcol;
        bus.clear_checkpoint_valid       = i.clv;
        bus.clear_checkpoint_column      = i.clcol;
    endtask

    task automatic chk(input string name, input string field,
                       input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
    endtask

    task automatic step(input in_t i, input exp_t e, input string name);
        @(negedge CLK);
        drive(i);
        #1;
        chk(name, "rs_tag",  int'(bus.rs_phys_reg_tag),            int'(e.rs_tag));
        chk(name, "rs_rdy",  int'(bus.rs_ready),                   int'(e.rs_rdy));
        chk(name, "rt_tag",  int'(bus.rt_phys_reg_tag),            int'(e.rt_tag));
        chk(name, "rt_rdy",  int'(bus.rt_ready),                   int'(e.rt_rdy));
        chk(name, "old_tag", int'(bus.rename_old_phys_reg_tag),    int'(e.old_tag));
        chk(name, "scol",    int'(bus.save_checkpoint_column),     int'(e.scol));
        chk(name, "sok",     int'(bus.save_checkpoint_success),    int'(e.sok));
        chk(name, "rok",     int'(bus.restore_checkpoint_success), int'(e.rok));
    endtask

    task automatic do_reset();
        @(negedge CLK);
        drive(mk_in(0,0, 0,0,0, 0,0, 0,0, 0,0,0, 0,0));
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    vec_t tbl[11];

    initial begin
        //                 rs rt ren ra rtag cv ctag sv srob rv rrob rcol clv clcol
        //                 rs_tag rs_rdy rt_tag rt_rdy old scol sok rok
        tbl[0]  = '{mk_in(5,31, 0,0,0,  0,0,  0,0, 0,0,0, 0,0), mk_exp(5,1,31,1, 0,0,0,0)};
        tbl[1]  = '{mk_in(3,0,  1,3,40, 0,0,  0,0, 0,0,0, 0,0), mk_exp(3,1,0,1,  3,0,0,0)};
        tbl[2]  = '{mk_in(3,0,  0,0,0,  0,0,  0,0, 0,0,0, 0,0), mk_exp(40,0,0,1, 0,0,0,0)};
        tbl[3]  = '{mk_in(3,0,  0,0,0,  1,40, 0,0, 0,0,0, 0,0), mk_exp(40,1,0,1, 0,0,0,0)};
        tbl[4]  = '{mk_in(3,0,  0,0,0,  0,0,  0,0, 0,0,0, 0,0), mk_exp(40,1,0,1, 0,0,0,0)};
        tbl[5]  = '{mk_in(4,3,  1,4,41, 0,0,  1,7, 0,0,0, 0,0), mk_exp(4,1,40,1, 4,0,1,0)};
        tbl[6]  = '{mk_in(4,3,  0,0,0,  0,0,  0,0, 0,0,0, 0,0), mk_exp(41,0,40,1,0,1,0,0)};
        tbl[7]  = '{mk_in(4,3,  1,4,42, 0,0,  0,0, 0,0,0, 0,0), mk_exp(41,0,40,1,41,1,0,0)};
        tbl[8]  = '{mk_in(4,5,  1,5,45, 0,0,  0,0, 1,8,0, 0,0), mk_exp(42,0,5,1, 5,1,0,0)};
        tbl[9]  = '{mk_in(4,5,  0,0,0,  0,0,  0,0, 1,7,0, 0,0), mk_exp(42,0,45,0,0,1,0,1)};
        tbl[10] = '{mk_in(4,5,  0,0,0,  0,0,  0,0, 0,0,0, 0,0), mk_exp(4,1,5,1,  0,1,0,0)};

        nRST = 1'b0;
        drive(mk_in(0,0, 0,0,0, 0,0, 0,0, 0,0,0, 0,0));
        do_reset();

        // Reset state, rename, CDB bypass, save/restore by ROB index
        for (int k = 0; k < 11; k++) begin
            step(tbl[k].i, tbl[k].e, $sformatf("vec%0d", k));
        end

        // Ring full: four saves succeed, fifth fails, clear frees column 0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(mk_in(0,0, 0,0,0, 0,0, 1,k, 0,0,0, 0,0), mk_exp(0,1,0,1,0,k,1,0),
                 $sformatf("full_save%0d", k));
        end
        step(mk_in(0,0, 0,0,0, 0,0, 1,4, 0,0,0, 0,0), mk_exp(0,1,0,1,0,0,0,0), "full_save4");
        step(mk_in(0,0, 0,0,0, 0,0, 0,0, 0,0,0, 1,0), mk_exp(0,1,0,1,0,0,0,0), "full_clear");
        step(mk_in(0,0, 0,0,0, 0,0, 1,4, 0,0,0, 0,0), mk_exp(0,1,0,1,0,0,1,0), "full_resave");
        step(mk_in(0,0, 0,0,0, 0,0, 1,5, 0,0,0, 0,0), mk_exp(0,1,0,1,0,1,0,0), "full_col1_busy");

        // CDB updates snapshots; restore invalidates restored + younger columns
        do_reset();
        step(mk_in(5,0, 0,0,0,  0,0,  1,1, 0,0,0, 0,0), mk_exp(5,1,0,1,0,0,1,0),   "cp_save0");
        step(mk_in(5,0, 1,5,50, 0,0,  0,0, 0,0,0, 0,0), mk_exp(5,1,0,1,5,1,0,0),   "cp_ren50");
        step(mk_in(5,0, 0,0,0,  0,0,  1,2, 0,0,0, 0,0), mk_exp(50,0,0,1,0,1,1,0),  "cp_save1");
        step(mk_in(5,0, 0,0,0,  1,50, 0,0, 0,0,0, 0,0), mk_exp(50,1,0,1,0,2,0,0),  "cp_cdb50");
        step(mk_in(5,0, 1,5,51, 0,0,  0,0, 0,0,0, 0,0), mk_exp(50,1,0,1,50,2,0,0), "cp_ren51");
        step(mk_in(5,0, 0,0,0,  0,0,  0,0, 1,2,1, 0,0), mk_exp(51,0,0,1,0,2,0,1),  "cp_rest1");
        step(mk_in(5,0, 0,0,0,  0,0,  1,3, 0,0,0, 0,0), mk_exp(50,1,0,1,0,2,1,0),  "cp_save2");
        step(mk_in(5,0, 0,0,0,  0,0,  0,0, 1,1,0, 0,0), mk_exp(50,1,0,1,0,3,0,1),  "cp_rest0");
        step(mk_in(5,0, 0,0,0,  0,0,  0,0, 1,3,2, 0,0), mk_exp(5,1,0,1,0,1,0,0),   "cp_col2_dead");
        step(mk_in(5,0, 0,0,0,  0,0,  1,4, 1,2,1, 0,0), mk_exp(5,1,0,1,0,1,1,0),   "cp_col1_dead");

        // Restore beats same-cycle rename and save
        do_reset();
        step(mk_in(6,0, 0,0,0,  0,0, 1,9,  0,0,0, 0,0), mk_exp(6,1,0,1,0,0,1,0),   "pri_save");
        step(mk_in(6,0, 1,6,61, 0,0, 0,0,  0,0,0, 0,0), mk_exp(6,1,0,1,6,1,0,0),   "pri_ren61");
        step(mk_in(6,0, 1,6,60, 0,0, 1,10, 1,9,0, 0,0), mk_exp(61,0,0,1,61,1,0,1), "pri_all");
        step(mk_in(6,0, 0,0,0,  0,0, 1,11, 0,0,0, 0,0), mk_exp(6,1,0,1,0,1,1,0),   "pri_after");

        // Rename beats CDB on same tag, arch reg 0, save beats clear, reset mid-op
        do_reset();
        step(mk_in(7,0, 1,7,45, 1,45, 0,0, 0,0,0, 0,0), mk_exp(7,1,0,1,7,0,0,0),   "misc_ren_cdb");
        step(mk_in(7,0, 1,0,33, 0,0,  0,0, 0,0,0, 0,0), mk_exp(45,0,0,1,0,0,0,0),  "misc_ren_r0");
        step(mk_in(0,7, 0,0,0,  0,0,  0,0, 0,0,0, 0,0), mk_exp(0,1,45,0,0,0,0,0),  "misc_r0_kept");
        step(mk_in(7,0, 0,0,0,  0,0,  1,5, 0,0,0, 1,0), mk_exp(45,0,0,1,0,0,1,0),  "misc_save_clr");
        step(mk_in(7,0, 0,0,0,  0,0,  0,0, 1,5,0, 0,0), mk_exp(45,0,0,1,0,1,0,1),  "misc_rest");
        step(mk_in(7,0, 1,7,46, 0,0,  0,0, 0,0,0, 0,0), mk_exp(45,0,0,1,45,1,0,0), "misc_pending");
        do_reset();
        step(mk_in(7,0, 0,0,0,  0,0,  0,0, 0,0,0, 0,0), mk_exp(7,1,0,1,0,0,0,0),   "misc_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/phys_reg_map_table.md
Name: phys_reg_map_table

Overview:
Register map table for the rename stage; consumes the physical tag dequeued from the free list each rename cycle.
- Holds the current architectural-to-physical mapping plus a ready bit per mapping.
- Returns the displaced (old) physical tag to the ROB; that tag is later re-enqueued to the free list at commit.
- Keeps per-branch checkpoint columns of the whole map, saved and restored in lockstep with the free list's checkpoint columns.

Parameters:
NUM_ARCH_REGS, 32, architectural registers; arch reg 0 hardwired, never renamed
NUM_PHYS_REGS, 64, physical registers; tag width LOG = 6
CHECKPOINT_COLUMNS, 4, snapshot columns; column index width 2
ROB_DEPTH, 16, ROB entries; ROB index width 4

Ports:
CLK  in  1  clock
nRST  in  1  reset, synchronous, active-low
rs_arch_reg  in  5  source A lookup
rt_arch_reg  in  5  source B lookup
rs_phys_reg_tag  out  6  current mapping of rs
rs_ready  out  1  rs value available
rt_phys_reg_tag  out  6  current mapping of rt
rt_ready  out  1  rt value available
rename_valid  in  1  rename dest this cycle
rename_arch_reg  in  5  destination arch reg
rename_phys_reg_tag  in  6  new tag from free list dequeue
rename_old_phys_reg_tag  out  6  previous mapping of rename_arch_reg, to ROB
complete_valid  in  1  CDB writeback
complete_phys_reg_tag  in  6  tag written back
save_checkpoint_valid  in  1  snapshot request (branch dispatch)
save_checkpoint_ROB_index  in  4  branch ROB index tag
save_checkpoint_column  out  2  column allocated (current tail)
save_checkpoint_success  out  1  snapshot accepted
restore_checkpoint_valid  in  1  mispredict restore
restore_checkpoint_ROB_index  in  4  ROB index to match
restore_checkpoint_column  in  2  column to restore
restore_checkpoint_success  out  1  restore performed
clear_checkpoint_valid  in  1  branch resolved correct / committed
clear_checkpoint_column  in  2  column to free

Behaviour:
- Reset (nRST=0 at posedge):
  - map[i] = i, ready[i] = 1 for all i.
  - All checkpoint columns invalid; tail column = 0.
  - Reset mid-operation discards all pending state.
- Lookups are combinational.
  - Tag comes from the map; ready = ready bit OR (complete_valid AND tag == complete_phys_reg_tag), i.e. same-cycle CDB bypass.
  - Lookups do NOT see a same-cycle rename; rename logic resolves intra-bundle dependences.
- Rename:
  - rename_old_phys_reg_tag = map[rename_arch_reg], combinational.
  - Next cycle: map[rename_arch_reg] = rename_phys_reg_tag, ready = 0.
  - rename_arch_reg == 0: table unchanged; old tag output is 0.
- Complete: every entry whose tag equals complete_phys_reg_tag gets ready = 1 next cycle, in the live map and in every valid column.
  - If a same-cycle rename writes that same tag, the rename wins (ready = 0).
- Save:
  - save_checkpoint_column = tail; success = save_checkpoint_valid AND column[tail] invalid.
  - On success: column captures the map/ready state BEFORE the same-cycle rename, plus same-cycle complete; records ROB index; valid = 1; tail = tail+1 mod 4.
  - On failure: no state change. The caller stalls; the free list uses the same column index.
- Restore:
  - success = restore_checkpoint_valid AND column valid AND stored ROB index == restore_checkpoint_ROB_index.
  - On success: map/ready = column contents OR same-cycle complete; tail = restore column + 1 mod 4.
  - Invalidate the restored column and all younger columns: from the restored column through old tail-1, circular.
- Priority in one cycle: restore > rename/save. On successful restore, same-cycle rename and save are ignored (success outputs 0).
  - Failed restore: rename/save proceed normally.
- Clear: column[clear_checkpoint_column].valid = 0 next cycle.
  - Clear on the column being saved in the same cycle: the save wins.
- All outputs are combinational from state and inputs; at reset all success outputs are 0 when no request is present.

Test Plan:
- Reset: rs=5, rt=31 -> tags 5, 31, both ready=1; save_checkpoint_column=0.
- Rename r3->40, then rs=3: old tag=3; next cycle rs tag=40, ready=0. CDB 40 -> ready=1 same cycle (bypass) and registered next cycle.
- Save with ROB 7 while renaming r4->41 -> column 0 keeps r4->4. Rename r4->42, then restore(ROB 7, col 0) -> r4->4, tail=1, success=1. Restore with ROB 8 -> success=0, no change.
- Four saves without clear -> columns 0-3 succeed; fifth save success=0, tail stays 0. Clear col 0, then save -> success, column 0.
- Save col0; rename r5->50; save col1; CDB 50 -> col1 r5 ready=1. Restore col0 -> columns 0 and 1 invalid, r5->5 ready=1.
- Same-cycle restore + rename r6->60 + save -> rename/save ignored, save success=0, r6 mapping is from the snapshot.
